// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and defaults, reused by receiver and transmitter
package spart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam logic IDLE_LEVEL   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } spart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_rx_if.sv
// rtl/spart_rx_if.sv - receiver line/bus-side signal bundle
interface spart_rx_if #(
  parameter int DATA_BITS = spart_pkg::DATA_BITS_DEF
);
  logic                 baud_en;
  logic                 rxd;
  logic                 rd_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output baud_en, rxd, rd_ack,
    input  rx_data, rda, frame_err, overrun
  );

  modport slave (
    input  baud_en, rxd, rd_ack,
    output rx_data, rda, frame_err, overrun
  );
endinterface

// File: rtl/spart_sync.sv
// rtl/spart_sync.sv - rxd double-flop synchronizer and mid-bit 3-sample majority voter
module spart_sync
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  localparam int TW        = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rxd,
  input  logic          i_baud_en,
  input  logic [TW-1:0] i_tick,
  output logic          o_rxs,
  output logic          o_vote
);

  localparam logic [TW-1:0] TICK_S0 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1 = TW'(OVERSAMPLE / 2);

  logic r_meta;
  logic r_rxs;
  logic r_smp0;
  logic r_smp1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= IDLE_LEVEL;
      r_rxs  <= IDLE_LEVEL;
      r_smp0 <= IDLE_LEVEL;
      r_smp1 <= IDLE_LEVEL;
    end else begin
      r_meta <= i_rxd;
      r_rxs  <= r_meta;
      // Third sample is the live rxs at tick M+1, so the vote is ready that cycle
      if (i_baud_en && i_tick == TICK_S0) r_smp0 <= r_rxs;
      if (i_baud_en && i_tick == TICK_S1) r_smp1 <= r_rxs;
    end
  end

  assign o_rxs  = r_rxs;
  assign o_vote = maj3(r_smp0, r_smp1, r_rxs);

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 receiver: frame FSM, counters, shift register, status flags
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  spart_rx_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  spart_state_e         r_state;
  spart_state_e         w_state_nxt;
  logic [TW-1:0]        r_tick;
  logic [TW-1:0]        w_tick_nxt;
  logic [BW-1:0]        r_bitn;
  logic [BW-1:0]        w_bitn_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rda;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rxs;
  logic w_vote;
  logic w_at_vote;
  logic w_at_wrap;
  logic w_shift_en;
  logic w_deliver;

  spart_sync #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_rxd     (bus.rxd),
    .i_baud_en (bus.baud_en),
    .i_tick    (r_tick),
    .o_rxs     (w_rxs),
    .o_vote    (w_vote)
  );

  assign w_at_vote = (r_tick == TICK_VOTE);
  assign w_at_wrap = (r_tick == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bitn  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bitn  <= w_bitn_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bitn_nxt  = r_bitn;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    if (bus.baud_en) begin
      w_tick_nxt = w_at_wrap ? '0 : r_tick + 1'b1;
      case (r_state)
        ST_IDLE: begin
          w_tick_nxt = '0;
          if (!w_rxs) w_state_nxt = ST_START;
        end
        ST_START: begin
          if (w_at_vote && w_vote) begin
            w_state_nxt = ST_IDLE;
            w_tick_nxt  = '0;
          end else if (w_at_wrap) begin
            w_state_nxt = ST_DATA;
            w_bitn_nxt  = '0;
          end
        end
        ST_DATA: begin
          w_shift_en = w_at_vote;
          if (w_at_wrap) begin
            if (r_bitn == BIT_LAST) w_state_nxt = ST_STOP;
            else                    w_bitn_nxt  = r_bitn + 1'b1;
          end
        end
        ST_STOP: begin
          // Leave mid stop bit so a back-to-back start edge is not missed
          if (w_at_vote) begin
            w_deliver   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_tick_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_data   <= '0;
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_deliver) begin
      // A read in the delivery cycle frees the buffer, so the new byte is accepted
      if (!r_rda || bus.rd_ack) begin
        r_rx_data   <= r_shift;
        r_rda       <= 1'b1;
        r_frame_err <= ~w_vote;
        r_overrun   <= r_overrun & ~bus.rd_ack;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (bus.rd_ack) begin
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rda       = r_rda;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - scoreboard bench for spart_rx with directed 8N1 frames
module tb_spart_rx;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spart_rx_if #(.DATA_BITS(8)) bus ();

  spart_rx #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       rda;
    logic       fe;
    logic       ov;
  } obs_t;

  obs_t exp_q[$];
  obs_t prev = '0;
  int   checks = 0;
  int   errors = 0;
  int   baud_cnt = 0;

  // baud_en every 4 clocks: one bit = 64 clocks
  initial begin
    bus.baud_en = 1'b0;
    forever begin
      @(negedge clk);
      baud_cnt++;
      bus.baud_en = (baud_cnt % 4 == 0);
    end
  end

  always @(negedge clk) begin
    obs_t cur;
    obs_t e;
    cur = {bus.rx_data, bus.rda, bus.frame_err, bus.overrun};
    if (rst && cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event data=%h rda=%b fe=%b ov=%b", cur.data, cur.rda, cur.fe, cur.ov);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL event got data=%h rda=%b fe=%b ov=%b expected data=%h rda=%b fe=%b ov=%b",
                   cur.data, cur.rda, cur.fe, cur.ov, e.data, e.rda, e.fe, e.ov);
        end
      end
    end
    prev = cur;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] d, input logic r, input logic f, input logic o);
    obs_t e;
    e = {d, r, f, o};
    exp_q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
  endtask

  // Start edge is driven on the negedge right after a baud_en posedge, so
  // stop tick M+1 lands on the 620th posedge after the edge (ack_at = 619).
  task automatic send(input logic [7:0] b, input logic stop_bit, input int bitper,
                      input int ack_at, input int abort_at);
    int guard;
    int bi;
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!bus.baud_en && guard < 16);
    @(negedge clk);
    for (int n = 0; n < 10 * bitper; n++) begin
      if (n == abort_at) begin
        rst = 1'b0;
        bus.rxd = 1'b1;
        bus.rd_ack = 1'b0;
        return;
      end
      bi = n / bitper;
      bus.rxd = (bi == 0) ? 1'b0 : (bi == 9) ? stop_bit : b[bi-1];
      bus.rd_ack = (n == ack_at);
      @(negedge clk);
    end
    bus.rxd = 1'b1;
    bus.rd_ack = 1'b0;
  endtask

  initial begin
    bus.rxd = 1'b1;
    bus.rd_ack = 1'b0;
    wait_clk(5);
    chk("reset_rda", bus.rda, 0);
    chk("reset_fe", bus.frame_err, 0);
    chk("reset_ov", bus.overrun, 0);
    chk("reset_data", bus.rx_data, 0);
    rst = 1'b1;
    wait_clk(6400);
    chk("idle_quiet", exp_q.size(), 0);

    expect_ev(8'hA5, 1, 0, 0);
    send(8'hA5, 1'b1, 64, -1, -1);
    chk("a5_before_stop_end", bus.rda, 1);
    wait_clk(64);
    expect_ev(8'hA5, 0, 0, 0);
    pulse_ack();
    wait_clk(8);

    expect_ev(8'h3C, 1, 1, 0);
    send(8'h3C, 1'b0, 64, -1, -1);
    wait_clk(128);
    expect_ev(8'h3C, 0, 0, 0);
    pulse_ack();
    wait_clk(8);

    expect_ev(8'h11, 1, 0, 0);
    send(8'h11, 1'b1, 64, -1, -1);
    wait_clk(64);
    expect_ev(8'h11, 1, 0, 1);
    send(8'h22, 1'b1, 64, -1, -1);
    wait_clk(64);
    expect_ev(8'h33, 1, 0, 0);
    send(8'h33, 1'b1, 64, 619, -1);
    wait_clk(64);
    expect_ev(8'h33, 0, 0, 0);
    pulse_ack();
    wait_clk(8);

    @(negedge clk);
    bus.rxd = 1'b0;
    wait_clk(16);
    bus.rxd = 1'b1;
    wait_clk(192);
    chk("glitch_state_idle", dut.r_state, ST_IDLE);
    chk("glitch_no_rda", bus.rda, 0);

    expect_ev(8'h5A, 1, 0, 0);
    send(8'h5A, 1'b1, 62, -1, -1);
    wait_clk(64);

    send(8'h96, 1'b1, 64, -1, 352);
    wait_clk(10);
    chk("midreset_rda", bus.rda, 0);
    chk("midreset_data", bus.rx_data, 0);
    chk("midreset_fe", bus.frame_err, 0);
    chk("midreset_ov", bus.overrun, 0);
    rst = 1'b1;
    wait_clk(64);

    expect_ev(8'hFF, 1, 0, 0);
    send(8'hFF, 1'b1, 64, -1, -1);
    wait_clk(64);
    chk("ff_rda", bus.rda, 1);
    chk("all_events_seen", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
# spart_rx

Serial receiver for the SPART. Consumes the oversampling enable produced by the baud rate generator, recovers 8N1 asynchronous frames from the `rxd` pin, and presents each byte in a holding register with a data-available flag for the bus interface. Reports framing errors and overrun, and rejects false start bits.

## Interface
- `OVERSAMPLE`, 16: `baud_en` pulses per bit time; must be even and at least 8.
- `DATA_BITS`, 8: data bits per frame, sent LSB first.

- `clk`  in  1  system clock, the same clock as the baud generator.
- `rst`  in  1  synchronous, active-low reset.
- `baud_en`  in  1  one-cycle pulse at `OVERSAMPLE` × baud rate, from the baud generator's sampling clock.
- `rxd`  in  1  asynchronous serial input; idle level is high.
- `rd_ack`  in  1  one-cycle pulse from the bus interface when the CPU reads the receive buffer.
- `rx_data`  out  DATA_BITS  holding register containing the last accepted byte.
- `rda`  out  1  receive data available.
- `frame_err`  out  1  stop bit of the byte in `rx_data` was sampled low.
- `overrun`  out  1  sticky flag: a byte arrived while `rda` was 1.

## Operation
- **Input synchronizer:** `rxd` passes through 2 flops, both reset to 1. All logic uses the synchronized value `rxs`.
- **Counters:**
  - `tick`: 0..OVERSAMPLE-1. Advances only on `baud_en` and wraps to 0.
  - `bitn`: 0..DATA_BITS-1.
- **Sampling:** the bit value is the majority of `rxs` at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The result is valid at tick M+1.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** on `baud_en` with `rxs`=0, go to START with `tick`=0.
  - **START:** at tick M+1, a majority of 1 means a false start: return to IDLE with no flags changed. At `tick` wrap, go to DATA with `bitn`=0.
  - **DATA:** at tick M+1, shift the voted bit into the MSB of the shift register (LSB-first reception). At `tick` wrap, increment `bitn`. After bit DATA_BITS-1 wraps, go to STOP.
  - **STOP:** at tick M+1, deliver the frame and go to IDLE immediately. The receiver does not wait for the end of the stop bit, so it can resync on a back-to-back start edge.
- **Delivery when `rda`=0:**
  - Load `rx_data` from the shift register.
  - `rda` ← 1.
  - `frame_err` ← NOT(voted stop bit).
- **Delivery when `rda`=1:**
  - The new byte is discarded.
  - `rx_data` and `frame_err` are unchanged.
  - `overrun` ← 1.
- **`rd_ack`:** clears `rda`, `frame_err` and `overrun`. `rx_data` holds its value.
- **Simultaneous delivery and `rd_ack`:** delivery wins.
  - `rx_data` gets the new byte.
  - `rda` stays 1.
  - `frame_err` takes the new value.
  - `overrun` clears.
- **`rd_ack` while `rda`=0:** no effect.
- **Reset (active-low `rst`, synchronous):**
  - FSM goes to IDLE; `tick` and `bitn` go to 0.
  - Shift register and `rx_data` go to 0x00.
  - `rda`, `frame_err` and `overrun` go to 0.
  - Synchronizer flops go to 1.
  - Reset mid-frame abandons the frame. Reception restarts on the next falling edge seen after reset is released.

## Timing
- `rxd` to `rxs`: 2 clk cycles.
- Start detection: first `baud_en` at which `rxs`=0, so up to 1/OVERSAMPLE bit of detection jitter.
- `rda` rises on the clk edge after the `baud_en` that carries stop tick M+1. For OVERSAMPLE=16 this is about 9.6 bit times after the start edge.
- All outputs are registered and change only on `clk` rising edges.
- Between `baud_en` pulses, all state holds.
- Tolerates a baud mismatch of ±3% at OVERSAMPLE=16.

## Structure
- **Shared package `spart_pkg`:**
  - FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - `OVERSAMPLE` and `DATA_BITS` defaults.
  - Idle line level constant.
  - These are reused by the future transmitter.
- **Sub-module `spart_sync`:** 2-flop synchronizer plus 3-sample majority voter. Exposes `rxs` and `vote`.
- **Top level:** FSM, counters, shift register and status flags.

## Test plan
- Reset with `rxd`=1 → `rda`=0, `frame_err`=0, `overrun`=0, `rx_data`=0x00. No activity for 100 bit times.
- Send 0xA5 (8N1, exact baud), then pulse `rd_ack` → `rx_data`=0xA5 and `rda`=1 before the end of the stop bit; after `rd_ack`, `rda`=0 and `rx_data`=0xA5.
- Send 0x3C with the stop bit driven low → `rda`=1, `frame_err`=1, `rx_data`=0x3C. A following `rd_ack` clears both flags.
- Send 0x11 then 0x22 with no `rd_ack` → `rx_data`=0x11, `overrun`=1, `rda`=1. Then send 0x33 with `rd_ack` in the delivery cycle → `rx_data`=0x33, `rda`=1, `overrun`=0.
- Drive a 4-tick low glitch on idle `rxd` → no `rda`, FSM back in IDLE. Then send 0x5A at +3% baud error → `rx_data`=0x5A.
- Assert `rst` in the middle of bit 4 of a frame → all outputs reset. The next frame, 0xFF, is received correctly with `rda`=1.
